// File: rtl/brc_seq_if.sv
// Request/response bundle for the multi-cycle branch comparator.
// The master side issues compare requests; the slave side is the comparator.
interface brc_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic [2:0]       i_funct3;
  logic             o_valid;
  logic             i_ready;
  logic             o_br_less;
  logic             o_br_equal;
  logic             o_br_taken;
  logic             o_busy;

  modport slave (
    input  i_flush, i_valid, i_rs1_data, i_rs2_data, i_funct3, i_ready,
    output o_ready, o_valid, o_br_less, o_br_equal, o_br_taken, o_busy
  );

  modport master (
    output i_flush, i_valid, i_rs1_data, i_rs2_data, i_funct3, i_ready,
    input  o_ready, o_valid, o_br_less, o_br_equal, o_br_taken, o_busy
  );
endinterface

// File: rtl/brc_seq.sv
// Multi-cycle RISC-V branch comparator: walks the operands SLICE bits per cycle,
// MSB slice first, and returns less/equal/taken over a valid/ready handshake.
module brc_seq #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  brc_seq_if.slave  bus
);
  // WIDTH must be a multiple of SLICE.
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       f3;
  logic [IDXW-1:0]  idx;
  logic             found_diff, diff_less;
  logic             valid_q, less_q, equal_q, taken_q;

  logic             accept;
  logic [WIDTH-1:0] a_shift, b_shift, sign_mask;
  logic [SLICE-1:0] a_slice, b_slice;
  logic             slice_ne, slice_lt;
  logic             decided, dec_less, dec_equal, dec_taken;

  assign accept    = (state == IDLE) && bus.i_valid && !bus.i_flush;
  assign sign_mask = bus.i_funct3[1] ? '0 : MSB_MASK;

  assign a_shift   = op_a >> (32'(idx) * SLICE);
  assign b_shift   = op_b >> (32'(idx) * SLICE);
  assign a_slice   = a_shift[SLICE-1:0];
  assign b_slice   = b_shift[SLICE-1:0];
  assign slice_ne  = (a_slice != b_slice);
  assign slice_lt  = (a_slice < b_slice);

  // Resolve the current slice into a decision; without early exit the first
  // difference seen is remembered and only reported at the last slice.
  always_comb begin
    decided   = 1'b0;
    dec_less  = 1'b0;
    dec_equal = 1'b0;
    if (EARLY_EXIT) begin
      if (slice_ne) begin
        decided  = 1'b1;
        dec_less = slice_lt;
      end else if (idx == '0) begin
        decided   = 1'b1;
        dec_equal = 1'b1;
      end
    end else if (idx == '0) begin
      decided = 1'b1;
      if (found_diff) begin
        dec_less = diff_less;
      end else if (slice_ne) begin
        dec_less = slice_lt;
      end else begin
        dec_equal = 1'b1;
      end
    end
  end

  always_comb begin
    dec_taken = 1'b0;
    case (f3)
      3'b000:         dec_taken = dec_equal;
      3'b001:         dec_taken = !dec_equal;
      3'b100, 3'b110: dec_taken = dec_less;
      3'b101, 3'b111: dec_taken = !dec_less;
      default:        dec_taken = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.i_flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.i_valid) state_n = BUSY;
        BUSY:    if (decided)     state_n = DONE;
        DONE:    if (bus.i_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_a       <= '0;
      op_b       <= '0;
      f3         <= '0;
      idx        <= '0;
      found_diff <= 1'b0;
      diff_less  <= 1'b0;
      valid_q    <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      taken_q    <= 1'b0;
    end else if (bus.i_flush) begin
      found_diff <= 1'b0;
      valid_q    <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Flipping the sign bits turns a signed compare into an unsigned one.
            op_a       <= bus.i_rs1_data ^ sign_mask;
            op_b       <= bus.i_rs2_data ^ sign_mask;
            f3         <= bus.i_funct3;
            idx        <= IDXW'(NSLICE - 1);
            found_diff <= 1'b0;
          end
        end
        BUSY: begin
          if (decided) begin
            valid_q <= 1'b1;
            less_q  <= dec_less;
            equal_q <= dec_equal;
            taken_q <= dec_taken;
          end else begin
            idx <= idx - 1'b1;
            if (!found_diff && slice_ne) begin
              found_diff <= 1'b1;
              diff_less  <= slice_lt;
            end
          end
        end
        DONE: begin
          if (bus.i_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready    = (state == IDLE) && !bus.i_flush;
  assign bus.o_busy     = (state == BUSY);
  assign bus.o_valid    = valid_q;
  assign bus.o_br_less  = less_q;
  assign bus.o_br_equal = equal_q;
  assign bus.o_br_taken = taken_q;
endmodule

// File: tb/tb_brc_seq.sv
// Directed bench for brc_seq: an early-exit instance (bus0) and a fixed-latency
// instance (bus1) sharing clock and reset.
module tb_brc_seq;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 i_clk = ~i_clk;

  brc_seq_if #(.WIDTH(32)) bus0 ();
  brc_seq_if #(.WIDTH(32)) bus1 ();

  brc_seq #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b1)) dut_ee (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus0)
  );

  brc_seq #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b0)) dut_fix (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus1)
  );

  // Present one request for a single accept edge; returns #1 after that edge.
  task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f);
    if (sel) begin
      bus1.i_rs1_data = a; bus1.i_rs2_data = b; bus1.i_funct3 = f; bus1.i_valid = 1'b1;
    end else begin
      bus0.i_rs1_data = a; bus0.i_rs2_data = b; bus0.i_funct3 = f; bus0.i_valid = 1'b1;
    end
    @(posedge i_clk); #1;
    bus0.i_valid = 1'b0;
    bus1.i_valid = 1'b0;
  endtask

  // Count edges after accept until o_valid, giving up after 20.
  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? bus1.o_valid : bus0.o_valid) && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input bit sel);
    if (sel) bus1.i_ready = 1'b1; else bus0.i_ready = 1'b1;
    @(posedge i_clk); #1;
    bus0.i_ready = 1'b0;
    bus1.i_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    n_checks++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", bus0.o_ready); end
    n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", bus0.o_valid); end
    n_checks++; if (bus0.o_br_less !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_less got %b want 0", bus0.o_br_less); end
    n_checks++; if (bus0.o_br_equal !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_equal got %b want 0", bus0.o_br_equal); end
    n_checks++; if (bus0.o_br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_taken got %b want 0", bus0.o_br_taken); end
    n_checks++; if (bus0.o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", bus0.o_busy); end
  endtask

  task automatic test_equal;
    int lat;
    send(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000);
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL beq_latency got %0d want 4", lat); end
    n_checks++; if (bus0.o_br_equal !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_equal got %b want 1", bus0.o_br_equal); end
    n_checks++; if (bus0.o_br_less !== 1'b0) begin n_fail++; $display("[TB] FAIL beq_less got %b want 0", bus0.o_br_less); end
    n_checks++; if (bus0.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_taken got %b want 1", bus0.o_br_taken); end
    consume(1'b0);
    n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL beq_release got %b want 0", bus0.o_valid); end
    send(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b001);
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL bne_latency got %0d want 4", lat); end
    n_checks++; if (bus0.o_br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL bne_taken got %b want 0", bus0.o_br_taken); end
    consume(1'b0);
  endtask

  task automatic test_signed;
    int lat;
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL blt_latency got %0d want 1", lat); end
    n_checks++; if (bus0.o_br_less !== 1'b1) begin n_fail++; $display("[TB] FAIL blt_less got %b want 1", bus0.o_br_less); end
    n_checks++; if (bus0.o_br_equal !== 1'b0) begin n_fail++; $display("[TB] FAIL blt_equal got %b want 0", bus0.o_br_equal); end
    n_checks++; if (bus0.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL blt_taken got %b want 1", bus0.o_br_taken); end
    consume(1'b0);
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL bltu_latency got %0d want 1", lat); end
    n_checks++; if (bus0.o_br_less !== 1'b0) begin n_fail++; $display("[TB] FAIL bltu_less got %b want 0", bus0.o_br_less); end
    n_checks++; if (bus0.o_br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL bltu_taken got %b want 0", bus0.o_br_taken); end
    consume(1'b0);
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
    wait_valid(1'b0, lat);
    n_checks++; if (bus0.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL bgeu_taken got %b want 1", bus0.o_br_taken); end
    consume(1'b0);
  endtask

  task automatic test_late_diff;
    int lat;
    send(1'b0, 32'h0000_0005, 32'h0000_0007, 3'b101);
    // Operand changes after accept must be ignored.
    bus0.i_rs1_data = 32'h0000_0007;
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL bge_latency got %0d want 4", lat); end
    n_checks++; if (bus0.o_br_less !== 1'b1) begin n_fail++; $display("[TB] FAIL bge_less got %b want 1", bus0.o_br_less); end
    n_checks++; if (bus0.o_br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL bge_taken got %b want 0", bus0.o_br_taken); end
    consume(1'b0);
  endtask

  task automatic test_fixed_latency;
    int lat;
    send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
    wait_valid(1'b1, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL fix_latency got %0d want 4", lat); end
    n_checks++; if (bus1.o_br_less !== 1'b1) begin n_fail++; $display("[TB] FAIL fix_less got %b want 1", bus1.o_br_less); end
    n_checks++; if (bus1.o_br_equal !== 1'b0) begin n_fail++; $display("[TB] FAIL fix_equal got %b want 0", bus1.o_br_equal); end
    n_checks++; if (bus1.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL fix_taken got %b want 1", bus1.o_br_taken); end
    consume(1'b1);
  endtask

  task automatic test_backpressure;
    int lat;
    send(1'b0, 32'h0000_0003, 32'h0000_0009, 3'b110);
    wait_valid(1'b0, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      n_checks++; if (bus0.o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid got %b want 1", bus0.o_valid); end
      n_checks++; if (bus0.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_taken got %b want 1", bus0.o_br_taken); end
      n_checks++; if (bus0.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_ready got %b want 0", bus0.o_ready); end
    end
    consume(1'b0);
    n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release_valid got %b want 0", bus0.o_valid); end
    n_checks++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready got %b want 1", bus0.o_ready); end
    n_checks++; if (bus0.o_br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_result_hold got %b want 1", bus0.o_br_taken); end
  endtask

  task automatic test_flush;
    int seen;
    send(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000);
    bus0.i_flush = 1'b1;
    @(posedge i_clk); #1;
    bus0.i_flush = 1'b0;
    #1;
    n_checks++; if (bus0.o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy got %b want 0", bus0.o_busy); end
    n_checks++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready got %b want 1", bus0.o_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      if (bus0.o_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL flush_no_valid got %0d want 0", seen); end
    // Flush together with a request in IDLE blocks the accept.
    bus0.i_rs1_data = 32'h1; bus0.i_rs2_data = 32'h2; bus0.i_funct3 = 3'b100;
    bus0.i_valid = 1'b1; bus0.i_flush = 1'b1;
    #1;
    n_checks++; if (bus0.o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_accept_ready got %b want 0", bus0.o_ready); end
    @(posedge i_clk); #1;
    bus0.i_valid = 1'b0; bus0.i_flush = 1'b0;
    n_checks++; if (bus0.o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_accept_busy got %b want 0", bus0.o_busy); end
    // Flush in DONE clears the registered results.
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
    wait_valid(1'b0, seen);
    bus0.i_flush = 1'b1;
    @(posedge i_clk); #1;
    bus0.i_flush = 1'b0;
    n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_done_valid got %b want 0", bus0.o_valid); end
    n_checks++; if (bus0.o_br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_done_taken got %b want 0", bus0.o_br_taken); end
    n_checks++; if (bus0.o_br_less !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_done_less got %b want 0", bus0.o_br_less); end
  endtask

  task automatic test_reset_mid;
    int seen;
    send(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000);
    @(posedge i_clk); #1;
    n_checks++; if (bus0.o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_pre_busy got %b want 1", bus0.o_busy); end
    i_rst = 1'b1;
    #1;
    n_checks++; if (bus0.o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_busy got %b want 0", bus0.o_busy); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      if (bus0.o_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_valid got %0d want 0", seen); end
    n_checks++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_ready got %b want 1", bus0.o_ready); end
  endtask

  initial begin
    bus0.i_flush = 1'b0; bus0.i_valid = 1'b0; bus0.i_ready = 1'b0;
    bus0.i_rs1_data = '0; bus0.i_rs2_data = '0; bus0.i_funct3 = '0;
    bus1.i_flush = 1'b0; bus1.i_valid = 1'b0; bus1.i_ready = 1'b0;
    bus1.i_rs1_data = '0; bus1.i_rs2_data = '0; bus1.i_funct3 = '0;
    test_reset;
    test_equal;
    test_signed;
    test_late_diff;
    test_fixed_latency;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/brc_seq.md
Name: brc_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two WIDTH-bit operands SLICE bits per cycle, MSB slice first, with optional early termination.
- Resolves the full RISC-V branch decision from funct3 and returns the result over a valid/ready handshake.
- Used where wide operands (WIDTH > 32) or a reduced comparator area make a single-cycle compare unsuitable, e.g. a shared compare unit behind the EX stage.

Parameters:
- WIDTH, 32, operand width in bits.
- SLICE, 8, bits compared per cycle; WIDTH % SLICE must be 0; SLICE >= 1.
- EARLY_EXIT, 1, 1 = finish as soon as a slice differs; 0 = always examine all slices (fixed latency).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous abort; returns the block to IDLE.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_rs1_data  in  WIDTH  operand A.
- i_rs2_data  in  WIDTH  operand B.
- i_funct3  in  3  branch funct3; also selects signedness.
- o_valid  out  1  result valid.
- i_ready  in  1  result consumed when o_valid && i_ready.
- o_br_less  out  1  A < B under the selected signedness.
- o_br_equal  out  1  A == B.
- o_br_taken  out  1  branch decision.
- o_busy  out  1  high in BUSY.

Behaviour:
- Reset: async on i_rst. State=IDLE; o_valid=0; o_br_less=0; o_br_equal=0; o_br_taken=0; o_busy=0. Operand and count registers are cleared.
- Derived values: NSLICE = WIDTH/SLICE. Slice index counter width = max(1, clog2(NSLICE)).
- Signedness: unsigned if funct3[1]=1, signed otherwise.
- Signed compare: invert the MSB of both captured operands at capture time, then compare unsigned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - o_ready = !i_flush.
  - On accept: capture operands (MSB-adjusted) and funct3; idx = NSLICE-1; go to BUSY.
- BUSY:
  - Each cycle compares slice idx (bits idx*SLICE+SLICE-1 : idx*SLICE).
  - Slices differ: less = (A slice < B slice), equal = 0, decided.
  - Slices equal and idx == 0: less = 0, equal = 1, decided.
  - Slices equal and idx != 0: idx decrements; stay in BUSY.
  - A difference is decided only when EARLY_EXIT=1. When EARLY_EXIT=0, the first difference is latched, later slices are ignored, and the block exits only at idx == 0.
  - On decision: register o_br_less, o_br_equal and o_br_taken; go to DONE.
- Branch decision o_br_taken by funct3:
  - 000 (BEQ): equal.
  - 001 (BNE): !equal.
  - 100 (BLT), 110 (BLTU): less.
  - 101 (BGE), 111 (BGEU): !less.
  - 010, 011: 0.
- Latency: o_valid rises N rising edges after the accept edge.
  - N = index of the first differing slice counted from the MSB (1..NSLICE) when EARLY_EXIT=1.
  - N = NSLICE always when EARLY_EXIT=0.
- DONE:
  - o_valid=1; results are held stable while i_ready=0.
  - On i_ready: go to IDLE, o_valid=0 at the next edge; result outputs hold their last value.
  - No new request is accepted in the same cycle.
- Outputs o_ready and o_busy are decoded from state. o_valid and the result outputs are registered.
- i_flush: highest synchronous priority in every state.
  - Next state IDLE; o_valid and result outputs cleared to 0.
  - A request presented in the same cycle is not accepted.
- Reset mid-operation: immediate IDLE; the in-flight compare is discarded and no o_valid is produced.
- Inputs are sampled only at accept; changes to them while BUSY or DONE have no effect.

Test Plan:
- Reset: hold i_rst across an edge, then release → o_ready=1, o_valid=0, all result outputs 0. Assert i_rst mid-BUSY → IDLE immediately, no o_valid.
- Equal, defaults (WIDTH=32, SLICE=8, EARLY_EXIT=1): A=B=32'h1234_5678, funct3=000 → o_valid after 4 edges; equal=1, less=0, taken=1. Same operands with funct3=001 → taken=0.
- Signed vs unsigned early exit: A=32'hFFFF_FFFF, B=32'h0000_0001.
  - funct3=100 → after 1 edge: less=1, equal=0, taken=1.
  - funct3=110 → after 1 edge: less=0, taken=0.
  - funct3=111 → taken=1.
- Late difference: A=32'h0000_0005, B=32'h0000_0007, funct3=101 → after 4 edges: less=1, taken=0.
- EARLY_EXIT=0 with the signed early-exit stimulus: A=32'hFFFF_FFFF, B=32'h0000_0001, funct3=100 → latency is exactly 4 edges; less=1, equal=0, taken=1.
- Backpressure and flush:
  - Hold i_ready=0 for 5 cycles in DONE → o_valid and results stable, o_ready=0; on i_ready=1, IDLE next edge.
  - Pulse i_flush during BUSY → IDLE next edge, no o_valid.
  - Assert i_flush together with i_valid in IDLE → request not accepted.
